// File: rtl/seg7_hex_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg7_hex_scan
// Function : Drives a 32-bit word as 8 hex digits on a multiplexed common-anode
//            7-segment display, latched once per frame.
// Revision : 1.0
// ============================================================================
module seg7_hex_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic        blank_lz,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame_tick
);

    localparam logic [CNT_W-1:0] c_DIV_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] r_div_cnt;
    logic [2:0]       r_idx;
    logic [31:0]      r_sh_data;
    logic             r_sh_blank_lz;
    logic [7:0]       r_sh_dp_mask;
    logic             r_valid;
    logic [7:0]       r_an;
    logic [7:0]       r_seg;
    logic             r_frame_tick;

    logic             w_div_wrap;
    logic             w_load;
    logic             w_blank;
    logic [31:0]      w_upper;
    logic [3:0]       w_nib;
    logic [6:0]       w_hex;
    logic [7:0]       w_an;
    logic [7:0]       w_seg;

    always_comb begin
        w_div_wrap = (r_div_cnt == c_DIV_LAST);
        w_load     = (r_div_cnt == '0) && (r_idx == 3'd0);
        // Everything from the current digit upward; zero means this digit is a leading zero.
        w_upper    = r_sh_data >> {r_idx, 2'b00};
        w_nib      = w_upper[3:0];
        w_blank    = r_sh_blank_lz && (r_idx != 3'd0) && (w_upper == 32'd0);
        w_an       = ~(8'd1 << r_idx);

        w_hex = 7'h7F;
        case (w_nib)
            4'h0:    w_hex = 7'h40;
            4'h1:    w_hex = 7'h79;
            4'h2:    w_hex = 7'h24;
            4'h3:    w_hex = 7'h30;
            4'h4:    w_hex = 7'h19;
            4'h5:    w_hex = 7'h12;
            4'h6:    w_hex = 7'h02;
            4'h7:    w_hex = 7'h78;
            4'h8:    w_hex = 7'h00;
            4'h9:    w_hex = 7'h10;
            4'hA:    w_hex = 7'h08;
            4'hB:    w_hex = 7'h03;
            4'hC:    w_hex = 7'h46;
            4'hD:    w_hex = 7'h21;
            4'hE:    w_hex = 7'h06;
            default: w_hex = 7'h0E;
        endcase

        w_seg = {~r_sh_dp_mask[r_idx], (w_blank ? 7'h7F : w_hex)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt     <= '0;
            r_idx         <= 3'd0;
            r_sh_data     <= 32'd0;
            r_sh_blank_lz <= 1'b0;
            r_sh_dp_mask  <= 8'd0;
            r_valid       <= 1'b0;
            r_an          <= 8'hFF;
            r_seg         <= 8'hFF;
            r_frame_tick  <= 1'b0;
        end else begin
            r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + CNT_W'(1);
            if (w_div_wrap) begin
                r_idx <= r_idx + 3'd1;
            end

            r_frame_tick <= w_load;
            if (w_load) begin
                r_sh_data     <= data;
                r_sh_blank_lz <= blank_lz;
                r_sh_dp_mask  <= dp_mask;
                r_valid       <= 1'b1;
            end

            // Decode uses the pre-edge shadow, so the load edge still shows the old frame.
            if (r_valid) begin
                r_an  <= w_an;
                r_seg <= w_seg;
            end else begin
                r_an  <= 8'hFF;
                r_seg <= 8'hFF;
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire
